// File: rtl/sobel_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sobel_read_scheduler
// Description : Read-address sequencer feeding sobelFilter from the source
//               frame SRAM. Each column group issues TAPS reads, walking up
//               the frame one row (ROW_WORDS words) per tap from the group's
//               base. After each group the base moves one column to the right.
//               At the end of a row it drops ROW_STEP rows. Groups are paced
//               by the filter's get_next request.
//               Optional feature macro: SCHED_CREDIT_EN (request credit
//               counter so get_next pulses seen mid-group are not lost).
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_read_scheduler #(
  parameter int          ADDR_W     = 20,
  parameter int          COL_W      = 8,
  parameter int          TAPS       = 4,
  parameter int          ROW_STEP   = 2,
  parameter int unsigned START_ADDR = 768,
  parameter int unsigned END_ADDR   = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_en,
  input  logic              get_next,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic [1:0]        tap_idx,
  output logic [COL_W-1:0]  col_pos,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] c_start    = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] c_end      = ADDR_W'(END_ADDR);
  // End-of-row step: next column plus (ROW_STEP-1) extra rows.
  localparam logic [ADDR_W-1:0] c_wrap_inc = ADDR_W'(1 + (ROW_STEP - 1) * (1 << COL_W));
  localparam logic [1:0]        c_last_tap = 2'(TAPS - 1);
  localparam logic [COL_W-1:0]  c_last_col = {COL_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;

  logic              w_grant;
  logic [1:0]        w_next_tap;
  logic [ADDR_W-1:0] w_next_tap_addr;
  logic [ADDR_W-1:0] w_next_base;
  logic              w_last_group;

  // Next-tap address, next-group base and end-of-frame detection.
  always_comb begin
    w_next_tap      = tap_idx + 2'd1;
    w_next_tap_addr = r_base - (ADDR_W'(w_next_tap) << COL_W);
    if (r_base[COL_W-1:0] == c_last_col) begin
      w_next_base = r_base + c_wrap_inc;
    end else begin
      w_next_base = r_base + ADDR_W'(1);
    end
    w_last_group = (r_base == c_end) || (w_next_base > c_end);
  end

`ifdef SCHED_CREDIT_EN
  logic [1:0] r_credit;
  logic       w_start_group;

  // A group starts from WAIT, or straight off the last tap when the frame continues.
  always_comb begin
    w_grant       = (r_credit != 2'd0) || get_next;
    w_start_group = w_grant &&
                    ((r_state == S_WAIT) ||
                     ((r_state == S_ISSUE) && (tap_idx == c_last_tap) && !w_last_group));
  end

  // Saturating request credit: +1 per get_next cycle, -1 per group started.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit <= 2'd0;
    end else if (r_state == S_IDLE) begin
      if (start_en) begin
        r_credit <= 2'd0;
      end
    end else if (get_next && !w_start_group) begin
      if (r_credit != 2'd3) begin
        r_credit <= r_credit + 2'd1;
      end
    end else if (!get_next && w_start_group) begin
      r_credit <= r_credit - 2'd1;
    end
  end
`else
  // Without credits the filter must hold get_next when a group can start.
  always_comb begin
    w_grant = get_next;
  end
`endif

  // Main sequencer; every output is registered with the state it enters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_base     <= c_start;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      tap_idx    <= 2'd0;
      col_pos    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          rd_en <= 1'b0;
          if (start_en) begin
            r_state <= S_PRIME;
            r_base  <= c_start;
            rd_addr <= c_start;
            col_pos <= c_start[COL_W-1:0];
            tap_idx <= 2'd0;
            busy    <= 1'b1;
          end
        end
        S_PRIME: begin
          // Address already presented; this cycle only fills the SRAM pipeline.
          r_state <= S_WAIT;
          rd_en   <= 1'b0;
        end
        S_WAIT: begin
          if (w_grant) begin
            r_state <= S_ISSUE;
            rd_addr <= r_base;
            rd_en   <= 1'b1;
            tap_idx <= 2'd0;
            col_pos <= r_base[COL_W-1:0];
          end else begin
            rd_en <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (tap_idx != c_last_tap) begin
            tap_idx <= w_next_tap;
            rd_addr <= w_next_tap_addr;
            rd_en   <= 1'b1;
          end else if (w_last_group) begin
            r_state    <= S_DONE;
            rd_en      <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            r_base  <= w_next_base;
            rd_addr <= w_next_base;
            col_pos <= w_next_base[COL_W-1:0];
            tap_idx <= 2'd0;
            if (w_grant) begin
              r_state <= S_ISSUE;
              rd_en   <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              rd_en   <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          rd_en   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          rd_en   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_read_scheduler
// Description : Directed self-checking bench for sobel_read_scheduler. One
//               instance uses default parameters, a second one uses a short
//               frame (END_ADDR = 770) to reach end of frame quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_read_scheduler;

  localparam int ADDR_W = 20;
  localparam int COL_W  = 8;

  logic clk;
  logic reset;

  // Default-parameter instance
  logic              start_en, get_next;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en, busy, frame_done;
  logic [1:0]        tap_idx;
  logic [COL_W-1:0]  col_pos;

  // Short-frame instance
  logic              start_en_e, get_next_e;
  logic [ADDR_W-1:0] rd_addr_e;
  logic              rd_en_e, busy_e, frame_done_e;
  logic [1:0]        tap_idx_e;
  logic [COL_W-1:0]  col_pos_e;

  int n_cmp;
  int n_err;

  sobel_read_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .start_en   (start_en),
    .get_next   (get_next),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .tap_idx    (tap_idx),
    .col_pos    (col_pos),
    .busy       (busy),
    .frame_done (frame_done)
  );

  sobel_read_scheduler #(.END_ADDR(770)) dut_e (
    .clk        (clk),
    .reset      (reset),
    .start_en   (start_en_e),
    .get_next   (get_next_e),
    .rd_addr    (rd_addr_e),
    .rd_en      (rd_en_e),
    .tap_idx    (tap_idx_e),
    .col_pos    (col_pos_e),
    .busy       (busy_e),
    .frame_done (frame_done_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks the full read group at base g, starting with the tap-0 cycle.
  task automatic check_group(input string tag, input int g);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk({tag, "_rd_en"},   32'(rd_en),   32'd1);
      chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(g - k * 256));
      chk({tag, "_tap_idx"}, 32'(tap_idx), 32'(k));
      chk({tag, "_col_pos"}, 32'(col_pos), 32'(g % 256));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    start_en   = 1'b0;
    get_next   = 1'b0;
    start_en_e = 1'b0;
    get_next_e = 1'b0;

    // ---- Reset state
    tick();
    tick();
    chk("rst_rd_addr",    32'(rd_addr),    32'd0);
    chk("rst_rd_en",      32'(rd_en),      32'd0);
    chk("rst_tap_idx",    32'(tap_idx),    32'd0);
    chk("rst_col_pos",    32'(col_pos),    32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // ---- Start with get_next held: PRIME, WAIT, then groups back-to-back
    start_en = 1'b1;
    get_next = 1'b1;
    tick();
    start_en = 1'b0;
    chk("prime_rd_addr", 32'(rd_addr), 32'd768);
    chk("prime_rd_en",   32'(rd_en),   32'd0);
    chk("prime_busy",    32'(busy),    32'd1);
    tick();
    chk("wait_rd_en", 32'(rd_en), 32'd0);
    chk("wait_busy",  32'(busy),  32'd1);
    // Groups 768..1023 with no bubble, including the row-end group at 1023
    for (int g = 768; g <= 1023; g++) begin
      check_group("run", g);
    end

    // ---- Row wrap: base after 1023 is 1023 + 257 = 1280, col 0
    tick();
    chk("wrap_rd_addr", 32'(rd_addr), 32'd1280);
    chk("wrap_col_pos", 32'(col_pos), 32'd0);
    chk("wrap_tap_idx", 32'(tap_idx), 32'd0);
    chk("wrap_rd_en",   32'(rd_en),   32'd1);
    tick();
    chk("wrap_tap1", 32'(rd_addr), 32'd1024);
    tick();
    chk("wrap_tap2", 32'(rd_addr), 32'd768);
    chk("wrap_tap2_idx", 32'(tap_idx), 32'd2);

    // ---- Asynchronous reset in the middle of a group (tap 2)
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rd_en",   32'(rd_en),   32'd0);
    chk("arst_busy",    32'(busy),    32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    chk("arst_tap_idx", 32'(tap_idx), 32'd0);
    get_next = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_rd_en", 32'(rd_en), 32'd0);

`ifndef SCHED_CREDIT_EN
    // ---- Restart at 768, then hold WAIT with get_next low
    start_en = 1'b1;
    get_next = 1'b1;
    tick();
    start_en = 1'b0;
    chk("restart_rd_addr", 32'(rd_addr), 32'd768);
    chk("restart_busy",    32'(busy),    32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("g768_rd_addr", 32'(rd_addr), 32'(768 - k * 256));
      if (k == 3) get_next = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rd_en", 32'(rd_en), 32'd0);
      chk("hold_busy",  32'(busy),  32'd1);
    end
    get_next = 1'b1;
    tick();
    chk("resume_rd_addr", 32'(rd_addr), 32'd769);
    chk("resume_rd_en",   32'(rd_en),   32'd1);
    chk("resume_tap_idx", 32'(tap_idx), 32'd0);
    // Pulses inside a group are not remembered: level is low on the last tap
    tick();
    get_next = 1'b0;
    chk("g769_tap1", 32'(rd_addr), 32'd513);
    tick();
    get_next = 1'b1;
    chk("g769_tap2", 32'(rd_addr), 32'd257);
    tick();
    get_next = 1'b0;
    chk("g769_tap3", 32'(rd_addr), 32'd1);
    tick();
    chk("lost_rd_en_0", 32'(rd_en), 32'd0);
    tick();
    chk("lost_rd_en_1", 32'(rd_en), 32'd0);
    chk("lost_busy",    32'(busy),  32'd1);
`else
    // ---- Credit mode: restart at 768 without requests
    start_en = 1'b1;
    tick();
    start_en = 1'b0;
    chk("restart_rd_addr", 32'(rd_addr), 32'd768);
    tick();
    chk("cr_wait_rd_en", 32'(rd_en), 32'd0);
    tick();
    chk("cr_wait2_rd_en", 32'(rd_en), 32'd0);
    // One request starts group 768; requests on taps 0,1,2 fill credit to 3
    get_next = 1'b1;
    tick();
    chk("cr_g768_tap0", 32'(rd_addr), 32'd768);
    tick();
    chk("cr_g768_tap1", 32'(rd_addr), 32'd512);
    tick();
    chk("cr_g768_tap2", 32'(rd_addr), 32'd256);
    tick();
    get_next = 1'b0;
    chk("cr_g768_tap3", 32'(rd_addr), 32'd0);
    // Group 769 starts from credit (3 -> 2); one more request -> 3, next dropped
    tick();
    get_next = 1'b1;
    chk("cr_g769_tap0", 32'(rd_addr), 32'd769);
    chk("cr_g769_en",   32'(rd_en),   32'd1);
    tick();
    chk("cr_g769_tap1", 32'(rd_addr), 32'd513);
    tick();
    get_next = 1'b0;
    chk("cr_g769_tap2", 32'(rd_addr), 32'd257);
    tick();
    chk("cr_g769_tap3", 32'(rd_addr), 32'd1);
    // Three more groups from the saved credit, then the sequencer waits
    for (int g = 770; g <= 772; g++) begin
      check_group("cr_run", g);
    end
    tick();
    chk("cr_drained_rd_en", 32'(rd_en), 32'd0);
    tick();
    chk("cr_drained2_rd_en", 32'(rd_en), 32'd0);
    chk("cr_drained_busy",   32'(busy),  32'd1);
`endif

    // ---- Short frame: groups 768..770, frame_done pulse, start_en ignored
    start_en_e = 1'b1;
    get_next_e = 1'b1;
    tick();
    start_en_e = 1'b0;
    chk("e_prime_rd_addr", 32'(rd_addr_e), 32'd768);
    chk("e_prime_busy",    32'(busy_e),    32'd1);
    tick();
    chk("e_wait_rd_en", 32'(rd_en_e), 32'd0);
    for (int g = 768; g <= 770; g++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("e_rd_en",   32'(rd_en_e),   32'd1);
        chk("e_rd_addr", 32'(rd_addr_e), 32'(g - k * 256));
        chk("e_tap_idx", 32'(tap_idx_e), 32'(k));
        chk("e_done_lo", 32'(frame_done_e), 32'd0);
        start_en_e = (g == 769 && k == 1);
      end
    end
    tick();
    chk("e_done_pulse", 32'(frame_done_e), 32'd1);
    chk("e_done_rd_en", 32'(rd_en_e),      32'd0);
    chk("e_done_busy",  32'(busy_e),       32'd1);
    tick();
    chk("e_idle_done", 32'(frame_done_e), 32'd0);
    chk("e_idle_busy", 32'(busy_e),       32'd0);
    chk("e_idle_rd_en", 32'(rd_en_e),     32'd0);
    tick();
    chk("e_idle2_done", 32'(frame_done_e), 32'd0);
    chk("e_idle2_busy", 32'(busy_e),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_read_scheduler.md
Name: sobel_read_scheduler

Overview:
- Synthesizable read-address sequencer feeding sobelFilter from the source frame SRAM (64-bit words, one row = ROW_WORDS words).
- For each column position it issues TAPS row-strided reads: base, base-ROW_WORDS, ..., base-(TAPS-1)*ROW_WORDS.
- It then advances the column and steps ROW_STEP rows at end of row.
- Paced by the filter's get_next handshake; frame runs from START_ADDR to END_ADDR and signals completion.

Parameters:
ADDR_W, 20, SRAM word-address width
COL_W, 8, log2(ROW_WORDS); ROW_WORDS = 1<<COL_W = 256
TAPS, 4, reads per column group (2..4)
ROW_STEP, 2, rows advanced at end of a row (1..3)
START_ADDR, 768, first base address; must be >= (TAPS-1)*ROW_WORDS
END_ADDR, 65535, last base address of a frame

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_en  in  1  frame start pulse; honoured only in IDLE
get_next  in  1  filter request for next column group
rd_addr  out  ADDR_W  SRAM read address (registered)
rd_en  out  1  rd_addr is a valid tap read this cycle
tap_idx  out  2  tap number of current read; 0 = base row
col_pos  out  COL_W  base[COL_W-1:0] of current group
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, any state): state=IDLE, rd_addr=0, rd_en=0, tap_idx=0, col_pos=0, busy=0, frame_done=0, base=START_ADDR, credit=0.
- All outputs are registered; values shown belong to the state being entered on that edge.
- IDLE: start_en=1 -> PRIME, base<=START_ADDR. get_next is ignored.
- PRIME (1 cycle): rd_addr=base, rd_en=0 (SRAM pipeline fill) -> WAIT.
- WAIT: rd_en=0. grant=1 -> ISSUE with tap 0; otherwise hold.
- ISSUE tap k:
  - rd_addr = base - k*ROW_WORDS, rd_en=1, tap_idx=k; one read per cycle, never stalled inside a group.
  - k < TAPS-1 -> next tap.
  - k = TAPS-1 and base==END_ADDR, or advance would exceed END_ADDR -> DONE.
  - Otherwise base advances and the state moves to ISSUE tap 0 if grant, else WAIT. Back-to-back groups have zero bubble.
- Base advance:
  - col_pos != ROW_WORDS-1 -> base+1.
  - col_pos == ROW_WORDS-1 -> base + 1 + (ROW_STEP-1)*ROW_WORDS (257 at defaults).
  - Arithmetic is ADDR_W wide, unsigned.
- DONE: frame_done=1 for exactly one cycle, rd_en=0 -> IDLE. busy drops on entry to IDLE.
- start_en while busy: ignored, no restart.
- grant without SCHED_CREDIT_EN: the get_next level, sampled in WAIT or on the last tap.
- Reset mid-group: outputs clear immediately; a partial group is not resumed.

Optional Feature:
SCHED_CREDIT_EN
- Defined:
  - A 2-bit saturating credit counter increments on each get_next cycle, including during ISSUE.
  - grant = (credit != 0) || get_next; starting a group consumes one credit.
  - Simultaneous increment and consume: count unchanged.
  - Saturates at 3; further requests are dropped.
  - Cleared on reset and on start_en accepted.
- Undefined:
  - No counter; grant = get_next level.
  - get_next pulses seen mid-group are lost.

Test Plan:
1. reset, start_en pulse, get_next held 1 -> PRIME rd_addr=768 rd_en=0. Then rd_addr 768,512,256,0 with tap_idx 0..3 on consecutive cycles. Next group 769,513,257,1 with no bubble.
2. Row wrap: force base 1023 (col_pos=255), get_next=1 -> group 1023,767,511,255, then next group base 1280 (col_pos=0).
3. get_next low after first group -> rd_en=0 and WAIT held 10 cycles. get_next=1 -> group 769.. begins next cycle.
4. END_ADDR=770, get_next=1 -> groups at 768,769,770, then frame_done single pulse, busy=0. start_en during frame has no effect.
5. Reset asserted on tap 2 mid-group -> rd_en, busy, rd_addr 0 asynchronously. New start_en restarts at 768.
6. SCHED_CREDIT_EN: three 1-cycle get_next pulses during a group -> three more groups issue back-to-back without further requests. A fifth pulse while credit=3 is dropped.
